// File: rtl/uart_work_loader_if.sv
// uart_work_loader_if
//   Groups the byte-input and record-output signals of uart_work_loader.
//   The byte source and record consumer use the master modport; the loader uses slave.
//   rx_data/rx_ready   : byte and byte-ready level/pulse from uart_rx
//   work_data          : assembled payload, first received byte in the MSBs
//   work_valid/ready   : record handshake toward the hashing core
//   err_checksum       : 1-cycle pulse, frame rejected on checksum
//   err_timeout        : 1-cycle pulse, frame aborted on inter-byte timeout
//   drop_count         : saturating count of bytes dropped while a record is held
interface uart_work_loader_if #(
  parameter int PAYLOAD_BYTES = 44
);
  logic [7:0]                 rx_data;
  logic                       rx_ready;
  logic [PAYLOAD_BYTES*8-1:0] work_data;
  logic                       work_valid;
  logic                       work_ready;
  logic                       err_checksum;
  logic                       err_timeout;
  logic [7:0]                 drop_count;

  modport master (
    output rx_data, rx_ready, work_ready,
    input  work_data, work_valid, err_checksum, err_timeout, drop_count
  );

  modport slave (
    input  rx_data, rx_ready, work_ready,
    output work_data, work_valid, err_checksum, err_timeout, drop_count
  );
endinterface

// File: rtl/uart_work_loader.sv
// uart_work_loader
//   Turns the uart_rx byte stream into framed, checksummed work records.
//   Frame: SYNC_BYTE, PAYLOAD_BYTES payload bytes, one check byte such that the
//   8-bit sum of payload and check byte is zero. A good frame is held on
//   work_data/work_valid until accepted; bytes arriving meanwhile are dropped
//   and counted. A gap of TIMEOUT_CYCLES inside a frame aborts it.
// Ports
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : uart_work_loader_if.slave (byte input, record output, status)
module uart_work_loader #(
  parameter int         PAYLOAD_BYTES  = 44,
  parameter logic [7:0] SYNC_BYTE      = 8'h55,
  parameter int         TIMEOUT_CYCLES = 43400
) (
  input logic               clk,
  input logic               reset,
  uart_work_loader_if.slave bus
);

  localparam int DW = PAYLOAD_BYTES * 8;
  localparam int CW = $clog2(PAYLOAD_BYTES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST   = CW'(PAYLOAD_BYTES - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK, HOLD} state_t;

  state_t        state, state_next;
  logic          rx_ready_q;
  logic [DW-1:0] work_data;
  logic [CW-1:0] byte_cnt;
  logic [7:0]    sum;
  logic [TW-1:0] timer;
  logic [7:0]    drop_count;
  logic          err_checksum, err_timeout;

  logic       strobe;
  logic       timer_hit;
  logic [7:0] sum_final;
  logic       start, take, cs_fail, tmo, drop;

  // One byte per rising edge of rx_ready, so level and pulse sources both work.
  assign strobe    = bus.rx_ready & ~rx_ready_q;
  assign timer_hit = (timer == TIMER_LAST);
  assign sum_final = sum + bus.rx_data;

  // NOTE: every signal written here gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    take       = 1'b0;
    cs_fail    = 1'b0;
    tmo        = 1'b0;
    drop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (strobe && bus.rx_data == SYNC_BYTE) begin
          start      = 1'b1;
          state_next = PAYLOAD;
        end
      end
      PAYLOAD: begin
        // A strobe on the timeout cycle wins: the byte is taken, no abort.
        if (strobe) begin
          take = 1'b1;
          if (byte_cnt == CNT_LAST) state_next = CHECK;
        end else if (timer_hit) begin
          tmo        = 1'b1;
          state_next = IDLE;
        end
      end
      CHECK: begin
        if (strobe) begin
          if (sum_final == 8'h00) begin
            state_next = HOLD;
          end else begin
            cs_fail    = 1'b1;
            state_next = IDLE;
          end
        end else if (timer_hit) begin
          tmo        = 1'b1;
          state_next = IDLE;
        end
      end
      HOLD: begin
        // Bytes here are dropped, never parsed as sync, including on the release cycle.
        drop = strobe;
        if (bus.work_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state and datapath registers use non-blocking assignments so every
  // read in this block sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      rx_ready_q   <= 1'b0;
      work_data    <= '0;
      byte_cnt     <= '0;
      sum          <= 8'h00;
      timer        <= '0;
      drop_count   <= 8'h00;
      err_checksum <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      state        <= state_next;
      rx_ready_q   <= bus.rx_ready;
      err_checksum <= cs_fail;
      err_timeout  <= tmo;

      if (start) begin
        byte_cnt <= '0;
        sum      <= 8'h00;
        timer    <= '0;
      end else if (state == PAYLOAD || state == CHECK) begin
        if (strobe)          timer <= '0;
        else if (!timer_hit) timer <= timer + 1'b1;
      end

      if (take) begin
        work_data <= {work_data[DW-9:0], bus.rx_data};
        sum       <= sum_final;
        byte_cnt  <= byte_cnt + 1'b1;
      end

      if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

  // work_data only changes in PAYLOAD, so it is stable for the whole HOLD.
  assign bus.work_data    = work_data;
  assign bus.work_valid   = (state == HOLD);
  assign bus.err_checksum = err_checksum;
  assign bus.err_timeout  = err_timeout;
  assign bus.drop_count   = drop_count;

endmodule
